dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 115 +++++++++++
 tb/tb_dmem_resp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-side memory responder: word RAM plus GPIO/timer/status MMIO.
// Reads are combinational; writes and all register updates land on clk.
module dmem_resp #(
  parameter int RAM_WORDS = 1024,
  parameter int GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_we,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       data_readM,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]       mem [RAM_WORDS];
  logic [AW-1:0]     ram_idx;
  logic [29:0]       word;
  logic              hit_ram, hit_gpio, hit_mtime;
  logic              hit_cmp, hit_stat, hit_cnt;
  logic              bad_wr;
  logic [31:0]       gpio_rd;
  logic              unused_addr;

  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       mtime_q, mtime_d;
  logic [31:0]       cmp_q, cmp_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              ien_q, ien_d;

  assign word        = dmem_addr[31:2];
  assign ram_idx     = dmem_addr[AW+1:2];
  assign unused_addr = ^dmem_addr[1:0];

  assign hit_ram   = (dmem_addr[31:12] == 20'h0);
  assign hit_gpio  = (word == 30'h400);
  assign hit_mtime = (word == 30'h401);
  assign hit_cmp   = (word == 30'h402);
  assign hit_stat  = (word == 30'h403);
  assign hit_cnt   = (word == 30'h404);

  // MTIME and STORE_CNT are read-only, so stores to them count as errors
  assign bad_wr = !(hit_ram | hit_gpio | hit_cmp | hit_stat);

  always_comb begin
    gpio_rd = '0;
    gpio_rd[GPIO_W-1:0] = gpio_q;
  end

  always_comb begin
    unique case (1'b1)
      hit_ram:   data_readM = mem[ram_idx];
      hit_gpio:  data_readM = gpio_rd;
      hit_mtime: data_readM = mtime_q;
      hit_cmp:   data_readM = cmp_q;
      hit_stat:  data_readM = {29'b0, ien_q, err_q, pend_q};
      hit_cnt:   data_readM = cnt_q;
      default:   data_readM = '0;
    endcase
  end

  always_comb begin
    gpio_d  = gpio_q;
    cmp_d   = cmp_q;
    ien_d   = ien_q;
    mtime_d = mtime_q + 32'd1;
    cnt_d   = cnt_q + {31'b0, dmem_we};
    // Set beats a same-cycle write-1-clear for both sticky bits
    pend_d  = pend_q;
    err_d   = err_q;
    if (dmem_we && hit_gpio) gpio_d = dmem_wdata[GPIO_W-1:0];
    if (dmem_we && hit_cmp)  cmp_d  = dmem_wdata;
    if (dmem_we && hit_stat) begin
      ien_d = dmem_wdata[2];
      if (dmem_wdata[0]) pend_d = 1'b0;
      if (dmem_wdata[1]) err_d  = 1'b0;
    end
    if (mtime_q == cmp_q)   pend_d = 1'b1;
    if (dmem_we && bad_wr)  err_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q  <= '0;
      mtime_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      ien_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      ien_q   <= ien_d;
    end
  end

  // RAM keeps its contents across reset; only the write is blocked
  always_ff @(posedge clk) begin
    if (!rst && dmem_we && hit_ram) mem[ram_idx] <= dmem_wdata;
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = pend_q & ien_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios then random traffic,
// all checked against a cycle-level reference model of the memory map.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] data_readM;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int tests = 0;
  int fails = 0;

  bit [31:0] m_ram [int];
  bit [7:0]  m_gpio;
  bit [31:0] m_mtime, m_cmp, m_cnt;
  bit        m_pend, m_err, m_ien;

  dmem_resp #(.RAM_WORDS(1024), .GPIO_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .data_readM(data_readM),
    .gpio_out(gpio_out),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_read(input logic [31:0] a,
                                output logic [31:0] v);
    v = 32'h0;
    if (a[31:12] == 20'h0) begin
      if (!m_ram.exists(int'(a[11:2]))) return 1'b0;
      v = m_ram[int'(a[11:2])];
      return 1'b1;
    end
    case (a[31:2])
      30'h400: v = {24'h0, m_gpio};
      30'h401: v = m_mtime;
      30'h402: v = m_cmp;
      30'h403: v = {29'h0, m_ien, m_err, m_pend};
      30'h404: v = m_cnt;
      default: v = 32'h0;
    endcase
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_gpio  = '0;
    m_mtime = '0;
    m_cmp   = 32'hFFFF_FFFF;
    m_cnt   = '0;
    m_pend  = 0;
    m_err   = 0;
    m_ien   = 0;
  endtask

  task automatic m_edge(input bit we, input logic [31:0] a,
                        input logic [31:0] d);
    bit setp, clrp, clre, errs;
    setp = (m_mtime == m_cmp);
    clrp = 0;
    clre = 0;
    errs = 0;
    if (we) begin
      if (a[31:12] == 20'h0) m_ram[int'(a[11:2])] = d;
      else case (a[31:2])
        30'h400: m_gpio = d[7:0];
        30'h402: m_cmp = d;
        30'h403: begin
          clrp  = d[0];
          clre  = d[1];
          m_ien = d[2];
        end
        default: errs = 1;
      endcase
      m_cnt++;
    end
    m_pend = setp | (m_pend & ~clrp);
    m_err  = errs | (m_err & ~clre);
    m_mtime++;
  endtask

  task automatic check_now(input string tag);
    logic [31:0] v;
    if (m_read(dmem_addr, v)) chk({tag, ".rd"}, data_readM, v);
    chk({tag, ".gpio"}, {24'h0, gpio_out}, {24'h0, m_gpio});
    chk({tag, ".irq"}, {31'h0, timer_irq}, {31'h0, m_pend & m_ien});
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic step(input string tag, input bit we,
                      input logic [31:0] a, input logic [31:0] d);
    dmem_we    = we;
    dmem_addr  = a;
    dmem_wdata = d;
    #1;
    check_now(tag);
    @(posedge clk);
    m_edge(we, a, d);
    @(negedge clk);
  endtask

  task automatic rst_step(input string tag, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
    dmem_we    = we;
    dmem_addr  = a;
    dmem_wdata = d;
    rst        = 1'b1;
    #1;
    m_reset();
    check_now(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned k, sel;
    bit we;
    rst        = 1'b1;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h1010;
    dmem_wdata = 32'h0;
    rst_step("reset", 1'b0, 32'h100C, 32'h0);

    step("ram.old", 1'b1, 32'h10, 32'h1111_2222);
    step("ram.wr", 1'b1, 32'h10, 32'hDEAD_BEEF);
    step("ram.rd", 1'b0, 32'h13, 32'h0);
    chk("ram.alias", data_readM, 32'hDEAD_BEEF);

    step("gpio.wr", 1'b1, 32'h1000, 32'hA5);
    step("gpio.rd", 1'b0, 32'h1000, 32'h0);
    chk("gpio.val", data_readM, 32'hA5);
    step("unmap.rd", 1'b0, 32'h2000, 32'h0);

    rst_step("reset2", 1'b0, 32'h1004, 32'h0);
    step("cmp.wr", 1'b1, 32'h1008, 32'd20);
    step("ien.wr", 1'b1, 32'h100C, 32'h4);
    for (int i = 0; i < 22; i++) step("tmr", 1'b0, 32'h100C, 32'h0);
    chk("tmr.irq", {31'h0, timer_irq}, 32'h1);
    step("tmr.clr", 1'b1, 32'h100C, 32'h5);
    step("tmr.low", 1'b0, 32'h100C, 32'h0);

    step("ro.wr", 1'b1, 32'h1004, 32'h1234);
    step("ro.st", 1'b0, 32'h100C, 32'h0);
    step("ro.cnt", 1'b0, 32'h1010, 32'h0);
    step("err.clr", 1'b1, 32'h100C, 32'h2);

    step("burst0", 1'b1, 32'h40, 32'hB000_0000);
    step("burst1", 1'b1, 32'h44, 32'hB000_0001);
    step("burst2", 1'b1, 32'h48, 32'hB000_0002);
    rst_step("burst.rst", 1'b1, 32'h1010, 32'hFFFF);
    step("burst.mt", 1'b1, 32'h1004, 32'h0);
    step("burst.cnt", 1'b1, 32'h1010, 32'h0);
    step("burst5", 1'b1, 32'h4C, 32'hB000_0005);
    step("burst6", 1'b1, 32'h50, 32'hB000_0006);
    step("keep0", 1'b0, 32'h40, 32'h0);
    step("keep2", 1'b0, 32'h48, 32'h0);

    for (int i = 0; i < 16; i++)
      step("fill", 1'b1, 32'h100 + 32'(i * 4), $urandom);

    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      k   = $urandom_range(0, 15);
      we  = 1'($urandom_range(0, 1));
      d   = $urandom;
      if (sel < 4) a = 32'h100 + 32'(k * 4);
      else if (sel < 8) a = 32'h1000 + 32'((k % 5) * 4);
      else if (k < 4) a = 32'h1014;
      else if (k < 8) a = 32'h2000;
      else if (k < 12) a = 32'h8000_0000;
      else a = 32'h0000_1FFC;
      a[1:0] = 2'($urandom_range(0, 3));
      if (a[31:2] == 30'h402) d = m_mtime + $urandom_range(0, 8);
      if (a[31:2] == 30'h403) d = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) rst_step("rnd.rst", we, a, d);
      else step("rnd", we, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
